// File: rtl/sdram_slot_arbiter.sv
// Slot scheduler and three-port round-robin arbiter in front of the 8-cycle SDRAM controller.
// Optional refresh guard: define SDRAM_ARB_REFRESH_GUARD_EN to force an idle slot after REFRESH_MAX busy slots.
module sdram_slot_arbiter #(
  parameter int SLOT_LEN    = 8,
  parameter int CAPTURE     = 6,
  parameter int REFRESH_MAX = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  p_req,
  input  logic [2:0]  p_we,
  input  logic [71:0] p_addr,
  input  logic [47:0] p_din,
  input  logic [5:0]  p_ds,
  output logic [2:0]  p_ack,
  output logic [47:0] p_dout,
  output logic        sd_sync,
  output logic        sd_oe,
  output logic        sd_we,
  output logic [23:0] sd_addr,
  output logic [15:0] sd_din,
  output logic [1:0]  sd_ds,
  input  logic [15:0] sd_dout
);
  localparam int CW = $clog2(SLOT_LEN);
  localparam logic [CW-1:0] LAST = CW'(SLOT_LEN - 1);
  localparam logic [CW-1:0] CAP  = CW'(CAPTURE);
  localparam logic [1:0]    NONE = 2'd3;

  logic [CW-1:0] cnt;
  logic [1:0]    rr_ptr;
  logic [1:0]    owner;
  logic [2:0]    own_mask;
  logic [1:0]    pick;
  logic          force_idle;
  logic          grant_vld;
  logic          sel_we;
  logic [23:0]   sel_addr;
  logic [15:0]   sel_din;
  logic [1:0]    sel_ds;

  // First eligible port scanning from (last + 1) mod 3; NONE when nobody is eligible.
  function automatic logic [1:0] rr_pick(input logic [2:0] elig, input logic [1:0] last);
    logic [1:0] sel;
    sel = NONE;
    for (int k = 3; k >= 1; k--) begin
      int idx;
      idx = (int'(last) + k) % 3;
      if (elig[idx]) sel = 2'(idx);
    end
    return sel;
  endfunction

  always_comb begin
    own_mask = '0;
    sel_we   = 1'b0;
    sel_addr = '0;
    sel_din  = '0;
    sel_ds   = '0;
    for (int i = 0; i < 3; i++) begin
      if (owner == 2'(i)) own_mask[i] = 1'b1;
    end
    pick = rr_pick(p_req & ~own_mask, rr_ptr);
    for (int i = 0; i < 3; i++) begin
      if (pick == 2'(i)) begin
        sel_we   = p_we[i];
        sel_addr = p_addr[24*i +: 24];
        sel_din  = p_din[16*i +: 16];
        sel_ds   = p_ds[2*i +: 2];
      end
    end
  end

`ifdef SDRAM_ARB_REFRESH_GUARD_EN
  logic [4:0] busy_cnt;
  assign force_idle = (busy_cnt == 5'(REFRESH_MAX));
  always_ff @(posedge clk) begin
    if (reset) busy_cnt <= '0;
    else if (cnt == LAST) busy_cnt <= grant_vld ? busy_cnt + 5'd1 : 5'd0;
  end
`else
  assign force_idle = 1'b0;
`endif

  assign grant_vld = !force_idle && (pick != NONE);

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt     <= LAST;
      rr_ptr  <= 2'd2;
      owner   <= NONE;
      sd_sync <= 1'b0;
      sd_oe   <= 1'b0;
      sd_we   <= 1'b0;
      sd_addr <= '0;
      sd_din  <= '0;
      sd_ds   <= '0;
      p_ack   <= '0;
      p_dout  <= '0;
    end else begin
      cnt     <= (cnt == LAST) ? '0 : cnt + CW'(1);
      sd_sync <= (cnt == LAST);
      p_ack   <= '0;
      // Slot boundary: latch the winner's command for the whole next slot.
      if (cnt == LAST) begin
        if (grant_vld) begin
          owner   <= pick;
          rr_ptr  <= pick;
          sd_oe   <= ~sel_we;
          sd_we   <= sel_we;
          sd_addr <= sel_addr;
          sd_din  <= sel_din;
          sd_ds   <= sel_ds;
        end else begin
          owner <= NONE;
          sd_oe <= 1'b0;
          sd_we <= 1'b0;
        end
      end
      // Completion: capture read data and pulse the owner's ack in the following cycle.
      if (cnt == CAP) begin
        for (int i = 0; i < 3; i++) begin
          if (owner == 2'(i)) begin
            p_ack[i] <= 1'b1;
            if (sd_oe) p_dout[16*i +: 16] <= sd_dout;
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_sdram_slot_arbiter.sv
// Bench for sdram_slot_arbiter: vector table, directed corner sequences, and random traffic vs a slot-level model.
module tb_sdram_slot_arbiter;
  localparam int SL = 8;
  localparam int CAPT = 6;
  localparam int RMAX = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic [2:0]  req;
  logic [2:0]  we_a;
  logic [23:0] addr_a [3];
  logic [15:0] din_a [3];
  logic [1:0]  ds_a [3];
  logic [15:0] sd_dout_v;

  logic [71:0] p_addr;
  logic [47:0] p_din;
  logic [5:0]  p_ds;
  logic [2:0]  p_ack;
  logic [47:0] p_dout;
  logic        sd_sync, sd_oe, sd_we;
  logic [23:0] sd_addr;
  logic [15:0] sd_din;
  logic [1:0]  sd_ds;

  assign p_addr = {addr_a[2], addr_a[1], addr_a[0]};
  assign p_din  = {din_a[2], din_a[1], din_a[0]};
  assign p_ds   = {ds_a[2], ds_a[1], ds_a[0]};

  sdram_slot_arbiter #(.SLOT_LEN(SL), .CAPTURE(CAPT), .REFRESH_MAX(RMAX)) dut (
    .clk(clk), .reset(reset), .p_req(req), .p_we(we_a), .p_addr(p_addr),
    .p_din(p_din), .p_ds(p_ds), .p_ack(p_ack), .p_dout(p_dout),
    .sd_sync(sd_sync), .sd_oe(sd_oe), .sd_we(sd_we), .sd_addr(sd_addr),
    .sd_din(sd_din), .sd_ds(sd_ds), .sd_dout(sd_dout_v)
  );

  int n_checks = 0;
  int n_fail = 0;

  // Slot-level reference: which port holds the current slot and what it asked for.
  int          m_phase, m_owner, m_last, m_busy;
  bit          m_oe, m_we;
  logic [23:0] m_addr;
  logic [15:0] m_din;
  logic [1:0]  m_ds;
  logic [2:0]  m_ack;
  logic [15:0] m_dout [3];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_edge();
    bit forced;
    int g;
    if (reset) begin
      m_phase = SL - 1; m_owner = -1; m_last = 2; m_busy = 0;
      m_oe = 0; m_we = 0; m_addr = '0; m_din = '0; m_ds = '0; m_ack = '0;
      for (int i = 0; i < 3; i++) m_dout[i] = '0;
      return;
    end
    m_phase = (m_phase + 1) % SL;
    m_ack = '0;
    if (m_phase == CAPT + 1 && m_owner >= 0) begin
      m_ack[m_owner] = 1'b1;
      if (m_oe) m_dout[m_owner] = sd_dout_v;
    end
    if (m_phase == 0) begin
      forced = 0;
`ifdef SDRAM_ARB_REFRESH_GUARD_EN
      forced = (m_busy == RMAX);
`endif
      g = -1;
      if (!forced) begin
        for (int k = 1; k <= 3; k++) begin
          int c;
          c = (m_last + k) % 3;
          if (g < 0 && req[c] && c != m_owner) g = c;
        end
      end
      if (g >= 0) begin
        m_owner = g; m_last = g; m_busy++;
        m_we = we_a[g]; m_oe = !we_a[g];
        m_addr = addr_a[g]; m_din = din_a[g]; m_ds = ds_a[g];
      end else begin
        m_owner = -1; m_busy = 0; m_oe = 0; m_we = 0;
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    chk("sync", sd_sync, m_phase == 0);
    chk("cmd", {sd_oe, sd_we, sd_ds, sd_din, sd_addr}, {m_oe, m_we, m_ds, m_din, m_addr});
    chk("ack", p_ack, m_ack);
    chk("dout", p_dout, {m_dout[2], m_dout[1], m_dout[0]});
  endtask

  task automatic run_to(input int ph);
    int n;
    n = 0;
    do begin
      step();
      n++;
    end while (m_phase != ph && n < 2 * SL);
    chk("run_to_bound", m_phase, ph);
  endtask

  task automatic clear_inputs();
    req = '0; we_a = '0; sd_dout_v = '0;
    for (int i = 0; i < 3; i++) begin
      addr_a[i] = '0; din_a[i] = '0; ds_a[i] = '0;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    clear_inputs();
    step();
    step();
    chk("reset_cmd", {sd_sync, sd_oe, sd_we, sd_addr, sd_din, sd_ds}, '0);
    chk("reset_outs", {p_ack, p_dout}, '0);
  endtask

  task automatic new_req(input int i);
    req[i] = 1'b1;
    we_a[i] = 1'($urandom);
    addr_a[i] = 24'($urandom);
    din_a[i] = 16'($urandom);
    ds_a[i] = 2'($urandom);
  endtask

  typedef struct {
    int          port;
    bit          we;
    logic [23:0] addr;
    logic [15:0] din;
    logic [1:0]  ds;
    logic [15:0] rd;
    logic [47:0] exp_dout;
  } vec_t;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vt [4];
    int grants [6];
    int exp_grants [6];
    int cnt_a, cnt_b;
    bit rel [3];

    vt[0] = '{0, 1'b0, 24'h000123, 16'h0000, 2'b11, 16'hBEEF, 48'h0000_0000_BEEF};
    vt[1] = '{1, 1'b1, 24'h00ABCD, 16'h1234, 2'b01, 16'h7777, 48'h0000_0000_0000};
    vt[2] = '{2, 1'b0, 24'hFFFFFF, 16'h0000, 2'b10, 16'h5A5A, 48'h5A5A_0000_0000};
    vt[3] = '{0, 1'b1, 24'h800001, 16'hCAFE, 2'b11, 16'h1111, 48'h0000_0000_0000};

    reset = 1'b1;
    clear_inputs();

    // Single transactions from reset: command held for one slot, ack at phase CAPT+1.
    foreach (vt[v]) begin
      int p;
      do_reset();
      p = vt[v].port;
      reset = 1'b0;
      req[p] = 1'b1; we_a[p] = vt[v].we; addr_a[p] = vt[v].addr;
      din_a[p] = vt[v].din; ds_a[p] = vt[v].ds; sd_dout_v = vt[v].rd;
      step();
      chk("t_sync", sd_sync, 1'b1);
      chk("t_cmd", {sd_oe, sd_we, sd_ds, sd_din, sd_addr},
          {!vt[v].we, vt[v].we, vt[v].ds, vt[v].din, vt[v].addr});
      for (int ph = 1; ph < SL; ph++) begin
        step();
        chk("t_hold", {sd_oe, sd_we, sd_addr}, {!vt[v].we, vt[v].we, vt[v].addr});
        chk("t_ack", p_ack, (ph == CAPT + 1) ? (3'b001 << p) : 3'b000);
      end
      chk("t_dout", p_dout, vt[v].exp_dout);
      step();
      chk("t_idle", {sd_oe, sd_we, sd_addr}, {2'b00, vt[v].addr});
      req[p] = 1'b0;
    end

    // All three saturated: strict rotation, guard inserts an idle slot after RMAX busy slots.
    do_reset();
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      req[i] = 1'b1; we_a[i] = (i == 1); addr_a[i] = 24'(i + 1) << 20; din_a[i] = 16'(i);
    end
`ifdef SDRAM_ARB_REFRESH_GUARD_EN
    exp_grants = '{0, 1, 2, 0, -1, 1};
`else
    exp_grants = '{0, 1, 2, 0, 1, 2};
`endif
    for (int s = 0; s < 6; s++) begin
      step();
      grants[s] = (sd_oe || sd_we) ? int'(sd_addr[21:20]) - 1 : -1;
      chk("sat_grant", grants[s], exp_grants[s]);
      repeat (SL - 1) step();
    end

    // One port holding req continuously gets alternate slots.
    do_reset();
    reset = 1'b0;
    req[2] = 1'b1; addr_a[2] = 24'h000222;
    cnt_a = 0; cnt_b = 0;
    for (int c = 0; c < 10 * SL; c++) begin
      step();
      if (p_ack[2]) cnt_a++;
      if (m_phase == 0 && (sd_oe || sd_we)) cnt_b++;
    end
    chk("alone_acks", cnt_a, 5);
    chk("alone_busy", cnt_b, 5);

    // Two saturating ports: idle slots only come from the refresh guard.
    do_reset();
    reset = 1'b0;
    req = 3'b011; addr_a[0] = 24'h10; addr_a[1] = 24'h20; we_a = 3'b010;
    cnt_a = 0;
    for (int s = 0; s < 10; s++) begin
      step();
      if (!sd_oe && !sd_we) cnt_a++;
      repeat (SL - 1) step();
    end
`ifdef SDRAM_ARB_REFRESH_GUARD_EN
    chk("guard_idle", cnt_a, 2);
`else
    chk("guard_idle", cnt_a, 0);
`endif

    // Reset in the middle of a read slot aborts it and clears read data.
    do_reset();
    reset = 1'b0;
    req[0] = 1'b1; addr_a[0] = 24'h000042; sd_dout_v = 16'h1111;
    run_to(CAPT + 1);
    chk("mid_prev_dout", p_dout, 48'h1111);
    run_to(0);
    run_to(0);
    chk("mid_regrant", {sd_oe, sd_addr}, {1'b1, 24'h000042});
    run_to(3);
    reset = 1'b1;
    step();
    chk("mid_rst_cmd", {sd_oe, sd_we, sd_addr, sd_sync}, '0);
    chk("mid_rst_outs", {p_ack, p_dout}, '0);
    reset = 1'b0;
    step();
    chk("mid_post_sync", sd_sync, 1'b1);
    chk("mid_post_oe", {sd_oe, sd_addr}, {1'b1, 24'h000042});
    req[0] = 1'b0;
    repeat (2 * SL) step();

    // Random traffic obeying the requester hold-until-ack rule.
    do_reset();
    reset = 1'b0;
    for (int i = 0; i < 3; i++) rel[i] = 0;
    for (int c = 0; c < 600; c++) begin
      step();
      sd_dout_v = 16'($urandom);
      for (int i = 0; i < 3; i++) begin
        if (rel[i]) begin
          rel[i] = 0;
          if ($urandom_range(1, 0) == 1) new_req(i);
          else req[i] = 1'b0;
        end else if (m_ack[i]) begin
          rel[i] = 1;
        end else if (!req[i] && $urandom_range(3, 0) == 0) begin
          new_req(i);
        end
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
